serial_addsub_ctrl: RTL and testbench

//  Sequences one external 1-bit full adder/subtractor cell (a,b,cin -> s,c) bit-serially
//  to perform a WIDTH-bit add or subtract. Handles operand capture, LSB-first bit feeding,

---
 rtl/serial_addsub_ctrl.sv | 131 +++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer driving one external full-adder cell.
// Operands are fed LSB-first and the result is assembled MSB-down, one bit per clock.
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             fa_a_o,
    output logic             fa_b_o,
    output logic             fa_cin_o,
    input  logic             fa_s_i,
    input  logic             fa_c_i
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aSh_q, aSh_d;
    logic [WIDTH-1:0] bSh_q, bSh_d;
    logic             subOp_q, subOp_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            aSh_q    <= '0;
            bSh_q    <= '0;
            subOp_q  <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            aSh_q    <= aSh_d;
            bSh_q    <= bSh_d;
            subOp_q  <= subOp_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Subtraction is a + ~b + 1: the cell sees b inverted and the carry starts at 1.
    always_comb begin
        state_d  = state_q;
        aSh_d    = aSh_q;
        bSh_d    = bSh_q;
        subOp_d  = subOp_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        fa_a_o   = 1'b0;
        fa_b_o   = 1'b0;
        fa_cin_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    aSh_d    = op_a_i;
                    bSh_d    = op_b_i;
                    subOp_d  = sub_i;
                    carry_d  = sub_i;
                    cnt_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                busy_o   = 1'b1;
                fa_a_o   = aSh_q[0];
                fa_b_o   = bSh_q[0] ^ subOp_q;
                fa_cin_o = carry_q;
                result_d = {fa_s_i, result_q[WIDTH-1:1]};
                carry_d  = fa_c_i;
                aSh_d    = aSh_q >> 1;
                bSh_d    = bSh_q >> 1;
                // Overflow: carry into the MSB differs from carry out of it.
                if (cnt_q == LAST_BIT) begin
                    cout_d  = fa_c_i;
                    ovf_d   = fa_c_i ^ carry_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result_o = result_q;
    assign cout_o   = cout_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Bench for serial_addsub_ctrl: behavioural full-adder cell plus a queue of expected results.
module tb_serial_addsub_ctrl;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] opA = '0;
    logic [WIDTH-1:0] opB = '0;
    logic             busy, done, cout, ovf;
    logic [WIDTH-1:0] result;
    logic             faA, faB, faCin, faS, faC;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign faS = faA ^ faB ^ faCin;
    assign faC = (faA & faB) | (faA & faCin) | (faB & faCin);

    serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .sub_i    (sub),
        .op_a_i   (opA),
        .op_b_i   (opB),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result),
        .cout_o   (cout),
        .ovf_o    (ovf),
        .fa_a_o   (faA),
        .fa_b_o   (faB),
        .fa_cin_o (faCin),
        .fa_s_i   (faS),
        .fa_c_i   (faC)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic, independent of the serial datapath.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic s);
        exp_t e;
        logic [WIDTH:0] full;
        if (s) full = {1'b0, a} + {1'b0, ~b} + 1;
        else   full = {1'b0, a} + {1'b0, b};
        e.res = full[WIDTH-1:0];
        e.c   = full[WIDTH];
        if (s) e.v = (a[WIDTH-1] != b[WIDTH-1]) && (e.res[WIDTH-1] != a[WIDTH-1]);
        else   e.v = (a[WIDTH-1] == b[WIDTH-1]) && (e.res[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    task automatic pushExpected(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic s);
        sb.push_back(model(a, b, s));
    endtask

    task automatic compareHead(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_result"}, 32'(result), 32'(e.res));
            check({tag, "_cout"}, 32'(cout), 32'(e.c));
            check({tag, "_ovf"}, 32'(ovf), 32'(e.v));
        end
    endtask

    // Returns just after the accepting edge with start released.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s);
        @(negedge clk);
        opA = a;
        opB = b;
        sub = s;
        start = 1'b1;
        pushExpected(a, b, s);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_latency"}, 32'(n), 32'(WIDTH));
            compareHead(tag);
            @(posedge clk);
            #1;
            check({tag, "_busy_after"}, 32'(busy), 32'd0);
            check({tag, "_done_after"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        int doneCount;
        int e;
        int k;
        exp_t held;
        logic [WIDTH-1:0] b2bA [3];
        logic [WIDTH-1:0] b2bB [3];
        logic             b2bS [3];

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_fa", 32'({faA, faB, faCin}), 32'd0);
        rst = 1'b0;

        // Plain adds, including carry-out and signed overflow
        applyStimulus(8'h35, 8'h4A, 1'b0);
        checkOutput("add_35_4a");
        applyStimulus(8'hFF, 8'h01, 1'b0);
        checkOutput("add_ff_01");
        applyStimulus(8'h7F, 8'h01, 1'b0);
        checkOutput("add_7f_01");

        // Subtracts: first bit must present inverted b and carry-in of 1
        applyStimulus(8'h10, 8'h20, 1'b1);
        check("sub_first_fa_a", 32'(faA), 32'd0);
        check("sub_first_fa_b", 32'(faB), 32'd1);
        check("sub_first_fa_cin", 32'(faCin), 32'd1);
        checkOutput("sub_10_20");
        applyStimulus(8'h80, 8'h01, 1'b1);
        checkOutput("sub_80_01");

        // Results hold while idle
        repeat (3) @(posedge clk);
        #1;
        check("hold_result", 32'(result), 32'h7F);
        check("hold_ovf", 32'(ovf), 32'd1);

        // Starts during RUN cycle 3 and during DONE are ignored
        applyStimulus(8'h12, 8'h34, 1'b0);
        doneCount = 0;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk);
            #1;
            opA = 8'h01;
            opB = 8'h01;
            sub = 1'b0;
            start = (i == 2) || done;
            if (done) begin
                doneCount++;
                compareHead("ignore");
            end
            if (i > 9) start = 1'b0;
        end
        start = 1'b0;
        check("ignore_done_count", 32'(doneCount), 32'd1);
        check("ignore_busy_idle", 32'(busy), 32'd0);
        check("ignore_result_kept", 32'(result), 32'h46);

        // Reset in the middle of RUN abandons the operation
        applyStimulus(8'h55, 8'h22, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_fa", 32'({faA, faB, faCin}), 32'd0);
        applyStimulus(8'h0A, 8'h05, 1'b0);
        checkOutput("after_rst");

        // Back-to-back with start held high: one accept every WIDTH+2 cycles
        b2bA[0] = 8'h11; b2bB[0] = 8'h22; b2bS[0] = 1'b0;
        b2bA[1] = 8'hC8; b2bB[1] = 8'h64; b2bS[1] = 1'b0;
        b2bA[2] = 8'h03; b2bB[2] = 8'h09; b2bS[2] = 1'b1;
        @(negedge clk);
        opA = b2bA[0];
        opB = b2bB[0];
        sub = b2bS[0];
        start = 1'b1;
        pushExpected(b2bA[0], b2bB[0], b2bS[0]);
        @(posedge clk);
        #1;
        e = 0;
        k = 0;
        while (k < 3 && e < 40) begin
            @(posedge clk);
            #1;
            e++;
            if (done) begin
                check("b2b_spacing", 32'(e), 32'(WIDTH + k * (WIDTH + 2)));
                compareHead("b2b");
                k++;
                if (k < 3) begin
                    opA = b2bA[k];
                    opB = b2bB[k];
                    sub = b2bS[k];
                    pushExpected(b2bA[k], b2bB[k], b2bS[k]);
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(k), 32'd3);
        @(posedge clk);
        #1;
        check("b2b_idle", 32'(busy), 32'd0);
        held = model(8'h03, 8'h09, 1'b1);
        check("b2b_last_held", 32'(result), 32'(held.res));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
